// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // MIPS "sll $0,$0,0": the word a squashed or empty stage presents downstream.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide enable flop with asynchronous active-low reset to RST_VAL.
module pipe_data_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: payload registers are reset (not left uninitialised like RAM) because
  // an empty stage must present the NOP on its output from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register (main + skid) with registered ready,
// synchronous flush and occupancy report.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(NOP_WORD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  state_e           state, state_nxt;
  logic             in_ready_q, out_valid_q;
  logic             in_fire, out_fire;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = FLUSH_VAL;
    skid_en   = 1'b0;
    skid_d    = FLUSH_VAL;

    if (flush) begin
      // Squash dominates: both registers fall back to the NOP.
      state_nxt = EMPTY;
      main_en   = 1'b1;
      skid_en   = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
            main_d    = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
            main_d  = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_en   = 1'b1;
            skid_d    = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
            main_en   = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_en   = 1'b1;
            main_d    = skid_q;
            skid_en   = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_en   = 1'b1;
          skid_en   = 1'b1;
        end
      endcase
    end
  end

  // Handshake outputs are flops fed from the next state, so neither side sees
  // a combinational path through this stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (FLUSH_VAL)
  ) u_main_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (FLUSH_VAL)
  ) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state;

endmodule
